// File: rtl/gpio_input_filter.sv
// gpio_input_filter: synchronises raw GPIO pads, optionally debounces each pin,
// detects clean edges and latches sticky per-pin interrupt-pending flags.
module gpio_input_filter #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] filt_en,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] gpio_in_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] r_s1, r_s2, r_clean, r_prev, r_pend, w_set;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_s1   <= pin_in;
      r_s2   <= r_s1;
      r_prev <= r_clean;
      r_pend <= w_set | (r_pend & ~irq_clr);
    end
  end
  // Loading s2 into clean is harmless when they already match, so pass-through,
  // stable input and an expired count share one update path.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) begin
        r_clean[i] <= 1'b0;
        r_cnt[i]   <= '0;
      end else if (!filt_en[i] || r_s2[i] == r_clean[i] || r_cnt[i] == LAST) begin
        r_clean[i] <= r_s2[i];
        r_cnt[i]   <= '0;
      end else begin
        r_cnt[i]   <= r_cnt[i] + 1'b1;
      end
    end
  end
  assign gpio_in_clean = r_clean;
  assign rise_pulse    = r_clean & ~r_prev;
  assign fall_pulse    = ~r_clean & r_prev;
  assign w_set         = (rise_pulse & rise_en) | (fall_pulse & fall_en);
  assign irq_pending   = r_pend;
  assign irq           = |r_pend;
endmodule

// File: tb/tb_gpio_input_filter.sv
// tb_gpio_input_filter: directed vector table plus hand sequences for the GPIO input filter.
module tb_gpio_input_filter;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] pin_in, filt_en, rise_en, fall_en, irq_clr;
  logic [W-1:0] gpio_in_clean, rise_pulse, fall_pulse, irq_pending;
  logic irq;
  int vec_cnt = 0;
  int err_cnt = 0;
  typedef struct {
    logic rst;
    logic [W-1:0] pin, filt, ren, fen, clr;
    logic [W-1:0] clean, rise, fall, pend;
    logic irq;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  gpio_input_filter #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .filt_en(filt_en), .rise_en(rise_en),
    .fall_en(fall_en), .irq_clr(irq_clr), .gpio_in_clean(gpio_in_clean),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .irq_pending(irq_pending), .irq(irq)
  );
  function automatic void add(logic r, logic [W-1:0] p, f, re, fe, c, ec, er, ef, ep, logic ei);
    tv.push_back('{r, p, f, re, fe, c, ec, er, ef, ep, ei});
  endfunction
  task automatic drive(logic r, logic [W-1:0] p, f, re, fe, c);
    rst = r; pin_in = p; filt_en = f; rise_en = re; fall_en = fe; irq_clr = c;
  endtask
  task automatic check(string name, logic [W-1:0] c, r, f, p, logic q);
    vec_cnt++;
    if ({gpio_in_clean, rise_pulse, fall_pulse, irq_pending, irq} !== {c, r, f, p, q}) begin
      err_cnt++;
      $display("FAIL %s: got clean=%h rise=%h fall=%h pend=%h irq=%b, want clean=%h rise=%h fall=%h pend=%h irq=%b",
               name, gpio_in_clean, rise_pulse, fall_pulse, irq_pending, irq, c, r, f, p, q);
    end
  endtask
  initial begin
    int n;
    // reset with pads high, then pass-through release
    add(1, 16'hFFFF, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 0, 0,  16'hFFFF, 16'hFFFF, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 0, 0,  16'hFFFF, 16'h0000, 0, 0, 0);
    // pass-through latency on pin 3
    add(1, 16'h0000, 0, 16'h0008, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0008, 0, 16'h0008, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0008, 0, 16'h0008, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0008, 0, 16'h0008, 0, 0,        16'h0008, 16'h0008, 0, 0, 0);
    add(0, 16'h0008, 0, 16'h0008, 0, 0,        16'h0008, 0, 0, 16'h0008, 1);
    add(0, 16'h0008, 0, 16'h0008, 0, 16'h0008, 16'h0008, 0, 0, 0, 0);
    // glitch rejection on pin 0: 3 cycles high rejected, 4 accepted
    add(1, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 16'h0001, 0, 0, 16'h0001, 1);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0001, 16'h0001, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 16'h0001, 0, 0, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0001, 0, 0);
    add(0, 16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    // fall edge masked on pin 5
    add(1, 16'h0000, 0, 16'h0020, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0020, 0, 16'h0020, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0020, 0, 16'h0020, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0020, 0, 16'h0020, 0, 0,        16'h0020, 16'h0020, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0020, 0, 0,        16'h0020, 0, 0, 16'h0020, 1);
    add(0, 16'h0000, 0, 16'h0020, 0, 0,        16'h0020, 0, 0, 16'h0020, 1);
    add(0, 16'h0000, 0, 16'h0020, 0, 16'h0020, 0, 0, 16'h0020, 0, 0);
    add(0, 16'h0000, 0, 16'h0020, 0, 0,        0, 0, 0, 0, 0);
    // set beats simultaneous clear on pin 2
    add(1, 16'h0000, 0, 16'h0004, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0004, 0, 16'h0004, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0004, 0, 16'h0004, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h0004, 0, 16'h0004, 0, 0,        16'h0004, 16'h0004, 0, 0, 0);
    add(0, 16'h0004, 0, 16'h0004, 0, 16'h0004, 16'h0004, 0, 0, 16'h0004, 1);
    add(0, 16'h0004, 0, 16'h0004, 0, 16'h0004, 16'h0004, 0, 0, 0, 0);
    // pins 0 and 15 together, cleared one at a time
    add(1, 16'h0000, 0, 16'hFFFF, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 0,        0, 0, 0, 0, 0);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 0,        16'h8001, 16'h8001, 0, 0, 0);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 0,        16'h8001, 0, 0, 16'h8001, 1);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 16'h0001, 16'h8001, 0, 0, 16'h8000, 1);
    add(0, 16'h8001, 0, 16'hFFFF, 0, 16'h8000, 16'h8001, 0, 0, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].pin, tv[i].filt, tv[i].ren, tv[i].fen, tv[i].clr);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tv[i].clean, tv[i].rise, tv[i].fall, tv[i].pend, tv[i].irq);
    end
    // filtered latency on all pins, then reset mid-operation
    drive(1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    @(posedge clk); #1;
    drive(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0);
    n = 0;
    while (gpio_in_clean !== 16'hFFFF && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vec_cnt++;
    if (n != 6) begin
      err_cnt++;
      $display("FAIL filt_latency: got %0d edges, want 6", n);
    end
    check("filt_rise", 16'hFFFF, 16'hFFFF, 0, 0, 0);
    @(posedge clk); #1;
    check("filt_pend", 16'hFFFF, 0, 0, 16'hFFFF, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
